// File: rtl/mem_sweep_checker.sv
// Purpose : sweeps every BRAM word once and folds it into a 32-bit rotating signature,
//           then compares the result against an expected value captured at start.
// Latency : done rises DEPTH_MEM+1 cycles after the start edge. No backpressure; start is ignored while busy.
//
// Ports:
//   clk       - single clock, rising edge
//   reset     - asynchronous active-low reset; release is synchronised with a 2-flop stage
//   start     - single-cycle sweep request, honoured in IDLE or DONE
//   abort     - synchronous cancel of an in-progress sweep
//   exp_sig   - expected signature, captured on the start edge
//   raddr     - RAM read address
//   rdata     - RAM dout, valid one cycle after raddr
//   busy      - high while sweeping or draining the last read
//   done      - high once the sweep completes; held until the next start
//   pass      - valid while done; 1 when the signature matches the captured exp_sig
//   signature - running or final signature
//   word_cnt  - number of words folded in this sweep
module mem_sweep_checker #(
    parameter int WID_MEM   = 18,
    parameter int DEPTH_MEM = 4096,
    parameter int ADDR_W    = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       exp_sig,
    output logic [ADDR_W-1:0] raddr,
    input  logic [WID_MEM-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [31:0]       signature,
    output logic [16:0]       word_cnt
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);

    state_t      state;
    logic [1:0]  rst_sync;
    logic        rst_int_n;
    logic        rd_vld;
    logic [31:0] exp_q;
    logic [31:0] rdata_ext;
    logic [31:0] sig_fold;

    // Assertion is immediate (async clear of both flops); release reaches the
    // FSM only on the second clk edge after reset goes high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    // Narrow RAM words are zero-extended into the low bits of the signature.
    assign rdata_ext = 32'(rdata);
    assign sig_fold  = {signature[30:0], signature[31]} ^ rdata_ext;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state     <= IDLE;
            raddr     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            word_cnt  <= '0;
            signature <= 32'hFFFF_FFFF;
            rd_vld    <= 1'b0;
            exp_q     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // start beats abort here; abort has nothing to cancel
                    if (start) begin
                        state     <= SWEEP;
                        raddr     <= '0;
                        signature <= 32'hFFFF_FFFF;
                        word_cnt  <= '0;
                        exp_q     <= exp_sig;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        rd_vld    <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (abort) begin
                        // partial signature and count are left visible
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rd_vld <= 1'b0;
                    end else begin
                        // the address on raddr now returns data next cycle
                        rd_vld <= 1'b1;
                        if (rd_vld) begin
                            signature <= sig_fold;
                            word_cnt  <= word_cnt + 17'd1;
                        end
                        if (raddr == LAST_ADDR) begin
                            state <= DRAIN;
                        end else begin
                            raddr <= raddr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rd_vld <= 1'b0;
                    end else begin
                        // last word arrives now; pass is judged on the final value
                        signature <= sig_fold;
                        word_cnt  <= word_cnt + 17'd1;
                        rd_vld    <= 1'b0;
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= (sig_fold == exp_q);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_sweep_checker.md
Name: mem_sweep_checker

Overview:
- Readback stage directly downstream of the block-RAM memory wrapper.
- Owns the RAM read port: drives raddr and consumes the registered dout.
- On start, sweeps every address once and folds each word into a 32-bit rotating signature. Compares the result against a software-supplied expected value, so bitstream re-initialisation of BRAM contents can be checked in hardware.
- Read path assumes exactly 1 cycle of RAM read latency.

Parameters:
- WID_MEM, 18, RAM word width; legal range 1..32.
- DEPTH_MEM, 4096, number of words swept; legal range 2..65536.
- ADDR_W, 12, width of raddr; must satisfy 2**ADDR_W >= DEPTH_MEM.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  single-cycle request; sampled only in IDLE or DONE.
- abort  input  1  synchronous cancel of an in-progress sweep.
- exp_sig  input  32  expected signature; sampled on the start edge.
- raddr  output  ADDR_W  read address to the memory.
- rdata  input  WID_MEM  memory dout; valid 1 cycle after raddr.
- busy  output  1  high in SWEEP and DRAIN.
- done  output  1  high in DONE; held until the next start.
- pass  output  1  valid while done; 1 when signature == captured exp_sig.
- signature  output  32  running/final signature.
- word_cnt  output  17  number of words folded in this sweep.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, raddr=0, busy=0, done=0, pass=0, word_cnt=0.
  - signature=32'hFFFF_FFFF, rd_valid pipe=0, captured exp=0.
  - Deassertion is synchronised internally with a 2-flop release; FSM leaves reset on the second clk edge after release.
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE/DONE with start=1, at the start edge:
  - state->SWEEP, raddr=0, signature=FFFF_FFFF, word_cnt=0.
  - exp_sig captured; done=0, pass=0.
- SWEEP, each edge:
  - rd_valid<=1 (the address just presented will return data next cycle).
  - raddr increments.
  - When raddr==DEPTH_MEM-1 at an edge: state->DRAIN and raddr holds.
- Fold rule, at every edge with rd_valid=1:
  - signature <= {signature[30:0],signature[31]} ^ {{(32-WID_MEM){1'b0}},rdata}.
  - word_cnt <= word_cnt+1.
- DRAIN: one edge folds the last word, clears rd_valid, and moves state->DONE.
- DONE: done=1; pass=(signature==captured exp).
- Timing: start edge = edge 0. done first visible after edge DEPTH_MEM+1. word_cnt must equal DEPTH_MEM in DONE.
- raddr never exceeds DEPTH_MEM-1; it does not wrap during a sweep.
- start while busy: ignored, no restart.
- start in DONE: immediate new sweep, done drops the next cycle.
- abort=1 in SWEEP/DRAIN:
  - Next state IDLE; busy=0, done=0, pass=0, rd_valid cleared.
  - signature and word_cnt hold their partial values.
- abort in IDLE/DONE: no effect.
- abort and start on the same edge: abort wins in SWEEP/DRAIN; in IDLE/DONE, start wins.
- reset mid-sweep: immediate return to reset values; no partial done.
- rdata is ignored whenever rd_valid=0.

Test Plan:
- DEPTH_MEM=4, RAM contents 1,2,3,4, exp_sig=FFFF_FFFD, pulse start -> raddr 0,1,2,3 on consecutive cycles; done after edge 5; signature=FFFF_FFFD, pass=1, word_cnt=4.
- Same contents with exp_sig=FFFF_FFFF -> done=1, pass=0, signature=FFFF_FFFD.
- DEPTH_MEM=4, all-zero RAM -> signature=FFFF_FFFF; busy high for exactly 5 cycles.
- Default parameters with RAM loaded from its hex init file; golden signature computed by the bench model -> pass=1, word_cnt=4096, final raddr=4095.
- abort asserted at edge 2 of a DEPTH_MEM=4 sweep -> IDLE next cycle, busy=0, done=0; start pulsed 3 cycles later gives a full correct sweep with pass=1.
- reset driven low asynchronously mid-SWEEP between edges -> all outputs reach reset values before the next edge; start pulsed while busy has no effect (raddr sequence unbroken).
